// File: rtl/vend_pkg.sv
// Shared definitions for the coin acceptor: coin width, default denomination
// mask and the controller state encoding.
package vend_pkg;

    localparam int COIN_W = 4;

    // Bits 1, 5 and 10 set: 1, 5 and 10 NIS coins are legal.
    localparam logic [15:0] DEFAULT_ACCEPT_MASK = 16'h0422;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFUND = 1'b1
    } state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Handshake bundle between the vending controller and the coin acceptor.
// slave is the acceptor side and master is the controller/hopper side.
interface coin_acceptor_if
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
);

    logic                coin_valid;
    logic [COIN_W-1:0]   coin_input;
    logic                vend_req;
    logic [CREDIT_W-1:0] vend_price;
    logic                refund_req;
    logic                refund_ready;
    logic [CREDIT_W-1:0] credit;
    logic                coin_accept;
    logic                coin_reject;
    logic                vend_ack;
    logic                vend_nak;
    logic                refund_valid;
    logic [COIN_W-1:0]   refund_coin;
    logic                refund_done;
    logic                busy;

    modport slave (
        input  coin_valid, coin_input, vend_req, vend_price, refund_req, refund_ready,
        output credit, coin_accept, coin_reject, vend_ack, vend_nak,
               refund_valid, refund_coin, refund_done, busy
    );

    modport master (
        output coin_valid, coin_input, vend_req, vend_price, refund_req, refund_ready,
        input  credit, coin_accept, coin_reject, vend_ack, vend_nak,
               refund_valid, refund_coin, refund_done, busy
    );

endinterface

// File: rtl/coin_check.sv
// Combinational denomination logic: legality of a presented coin and the
// largest legal denomination that fits into a given budget (0 if none fits).
module coin_check
    import vend_pkg::*;
#(
    parameter logic [15:0] ACCEPT_MASK = DEFAULT_ACCEPT_MASK,
    parameter int          CREDIT_W    = 8
) (
    input  logic [COIN_W-1:0]   coin,
    input  logic [CREDIT_W-1:0] budget,
    output logic                legal,
    output logic [COIN_W-1:0]   largest
);

    // A coin is legal when its value is nonzero and enabled in the mask.
    always_comb begin
        legal = 1'b0;
        if ((coin != {COIN_W{1'b0}}) && ACCEPT_MASK[coin]) begin
            legal = 1'b1;
        end else begin
            legal = 1'b0;
        end
    end

    // Ascending scan keeps the highest enabled value that still fits the budget.
    always_comb begin
        largest = {COIN_W{1'b0}};
        for (int v = 1; v < (1 << COIN_W); v++) begin
            if (ACCEPT_MASK[v] && (v <= int'(budget))) begin
                largest = v[COIN_W-1:0];
            end else begin
                largest = largest;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor / credit keeper for a vending machine.
// IDLE: takes coins and vend requests (vend is settled against the credit held
// at the start of the cycle, a same-cycle coin against the post-vend credit).
// REFUND: pays out the credit largest-coin-first over a valid/ready handshake.
// After each accepted refund coin the next coin is offered in the very next
// cycle (no idle cycle), because the following denomination is looked up from
// the already decremented credit in the same clock.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int          CREDIT_W    = 8,
    parameter int          MAX_CREDIT  = 200,
    parameter logic [15:0] ACCEPT_MASK = DEFAULT_ACCEPT_MASK
) (
    input  logic            clk,
    input  logic            rst,
    coin_acceptor_if.slave  bus
);

    localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W + 1)'(MAX_CREDIT);

    // Refuse to build a block that could not refund a 1-unit remainder or
    // whose ceiling does not fit the credit register.
    generate
        if ((ACCEPT_MASK[1] == 1'b0) || (MAX_CREDIT >= (2 ** CREDIT_W))) begin : g_bad_params
            $error("coin_acceptor: ACCEPT_MASK[1] must be set and MAX_CREDIT < 2**CREDIT_W");
        end
    endgenerate

    state_t              state_r;
    logic [CREDIT_W-1:0] credit_r;
    logic                coin_accept_r;
    logic                coin_reject_r;
    logic                vend_ack_r;
    logic                vend_nak_r;
    logic                refund_valid_r;
    logic [COIN_W-1:0]   refund_coin_r;
    logic                refund_done_r;
    logic                busy_r;

    logic [CREDIT_W:0]   credit_ext_s;
    logic [CREDIT_W:0]   price_ext_s;
    logic [CREDIT_W:0]   coin_ext_s;
    logic [CREDIT_W:0]   refund_ext_s;
    logic [CREDIT_W:0]   post_vend_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic [CREDIT_W:0]   after_refund_s;
    logic                vend_ok_s;
    logic                coin_fits_s;
    logic [CREDIT_W-1:0] lookup_credit_s;
    logic                coin_legal_s;
    logic [COIN_W-1:0]   largest_s;

    coin_check #(
        .ACCEPT_MASK (ACCEPT_MASK),
        .CREDIT_W    (CREDIT_W)
    ) u_coin_check (
        .coin    (bus.coin_input),
        .budget  (lookup_credit_s),
        .legal   (coin_legal_s),
        .largest (largest_s)
    );

    // Credit arithmetic, one bit wider than the register so nothing wraps.
    always_comb begin
        credit_ext_s   = {1'b0, credit_r};
        price_ext_s    = {1'b0, bus.vend_price};
        coin_ext_s     = (CREDIT_W + 1)'(bus.coin_input);
        refund_ext_s   = (CREDIT_W + 1)'(refund_coin_r);
        vend_ok_s      = (credit_ext_s >= price_ext_s);
        post_vend_s    = credit_ext_s;
        if (bus.vend_req && vend_ok_s) begin
            post_vend_s = credit_ext_s - price_ext_s;
        end else begin
            post_vend_s = credit_ext_s;
        end
        coin_sum_s     = post_vend_s + coin_ext_s;
        coin_fits_s    = coin_legal_s && (coin_sum_s <= MAX_EXT);
        after_refund_s = credit_ext_s - refund_ext_s;
        lookup_credit_s = credit_r;
        if (state_r == ST_REFUND) begin
            lookup_credit_s = after_refund_s[CREDIT_W-1:0];
        end else begin
            lookup_credit_s = credit_r;
        end
    end

    // Controller state, credit and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            credit_r       <= {CREDIT_W{1'b0}};
            coin_accept_r  <= 1'b0;
            coin_reject_r  <= 1'b0;
            vend_ack_r     <= 1'b0;
            vend_nak_r     <= 1'b0;
            refund_valid_r <= 1'b0;
            refund_coin_r  <= {COIN_W{1'b0}};
            refund_done_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            coin_accept_r <= 1'b0;
            coin_reject_r <= 1'b0;
            vend_ack_r    <= 1'b0;
            vend_nak_r    <= 1'b0;
            refund_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.refund_req) begin
                        coin_reject_r <= bus.coin_valid;
                        vend_nak_r    <= bus.vend_req;
                        if (credit_r == {CREDIT_W{1'b0}}) begin
                            refund_done_r <= 1'b1;
                        end else begin
                            state_r        <= ST_REFUND;
                            busy_r         <= 1'b1;
                            refund_valid_r <= 1'b1;
                            refund_coin_r  <= largest_s;
                        end
                    end else begin
                        vend_ack_r    <= bus.vend_req && vend_ok_s;
                        vend_nak_r    <= bus.vend_req && !vend_ok_s;
                        coin_accept_r <= bus.coin_valid && coin_fits_s;
                        coin_reject_r <= bus.coin_valid && !coin_fits_s;
                        if (bus.coin_valid && coin_fits_s) begin
                            credit_r <= coin_sum_s[CREDIT_W-1:0];
                        end else begin
                            credit_r <= post_vend_s[CREDIT_W-1:0];
                        end
                    end
                end
                ST_REFUND: begin
                    coin_reject_r <= bus.coin_valid;
                    vend_nak_r    <= bus.vend_req;
                    if (refund_valid_r && bus.refund_ready) begin
                        credit_r <= after_refund_s[CREDIT_W-1:0];
                        if (after_refund_s == {(CREDIT_W + 1){1'b0}}) begin
                            state_r        <= ST_IDLE;
                            busy_r         <= 1'b0;
                            refund_valid_r <= 1'b0;
                            refund_coin_r  <= {COIN_W{1'b0}};
                            refund_done_r  <= 1'b1;
                        end else begin
                            refund_coin_r <= largest_s;
                        end
                    end else begin
                        refund_coin_r <= refund_coin_r;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    busy_r         <= 1'b0;
                    refund_valid_r <= 1'b0;
                    refund_coin_r  <= {COIN_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.credit       = credit_r;
    assign bus.coin_accept  = coin_accept_r;
    assign bus.coin_reject  = coin_reject_r;
    assign bus.vend_ack     = vend_ack_r;
    assign bus.vend_nak     = vend_nak_r;
    assign bus.refund_valid = refund_valid_r;
    assign bus.refund_coin  = refund_coin_r;
    assign bus.refund_done  = refund_done_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: default-mask instance (ifa) and a
// 1/2/5 mask instance (ifb), outputs sampled 1 time unit after each rising edge.
module tb_coin_acceptor;
    import vend_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    coin_acceptor_if #(.CREDIT_W(8)) ifa ();
    coin_acceptor_if #(.CREDIT_W(8)) ifb ();

    coin_acceptor #(.CREDIT_W(8), .MAX_CREDIT(200), .ACCEPT_MASK(16'h0422)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    coin_acceptor #(.CREDIT_W(8), .MAX_CREDIT(200), .ACCEPT_MASK(16'h0026)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic cv, input logic [3:0] ci, input logic vr,
                           input logic [7:0] vp, input logic rq);
        ifa.coin_valid = cv; ifa.coin_input = ci; ifa.vend_req = vr;
        ifa.vend_price = vp; ifa.refund_req = rq;
    endtask

    task automatic drive_b(input logic cv, input logic [3:0] ci, input logic rq);
        ifb.coin_valid = cv; ifb.coin_input = ci; ifb.vend_req = 1'b0;
        ifb.vend_price = 8'd0; ifb.refund_req = rq;
    endtask

    task automatic add_coins_a(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            drive_a(1'b1, v, 1'b0, 8'd0, 1'b0);
            cycle();
        end
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b0); ifa.refund_ready = 1'b0;
        drive_b(1'b0, 4'd0, 1'b0); ifb.refund_ready = 1'b0;
        rst = 1'b1;
        #12;
        total++; if (ifa.credit !== 8'd0) begin bad++; $display("FAIL reset_credit got=%0d want=0", ifa.credit); end
        total++; if ({ifa.busy, ifa.refund_valid, ifa.refund_coin} !== 6'd0) begin bad++; $display("FAIL reset_refund got=%b want=0", {ifa.busy, ifa.refund_valid, ifa.refund_coin}); end
        total++; if ({ifa.coin_accept, ifa.coin_reject, ifa.vend_ack, ifa.vend_nak, ifa.refund_done} !== 5'd0) begin bad++; $display("FAIL reset_pulses got=%b want=0", {ifa.coin_accept, ifa.coin_reject, ifa.vend_ack, ifa.vend_nak, ifa.refund_done}); end
        rst = 1'b0;
        cycle();
        total++; if (ifa.credit !== 8'd0) begin bad++; $display("FAIL reset_idle_credit got=%0d want=0", ifa.credit); end
    endtask

    task automatic test_coins();
        logic [3:0] coins [4] = '{4'd1, 4'd5, 4'd10, 4'd3};
        logic       acc   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] cred  [4] = '{8'd1, 8'd6, 8'd16, 8'd16};
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, coins[i], 1'b0, 8'd0, 1'b0);
            cycle();
            total++; if ({ifa.coin_accept, ifa.coin_reject} !== {acc[i], ~acc[i]}) begin bad++; $display("FAIL coins_pulse[%0d] got=%b want=%b", i, {ifa.coin_accept, ifa.coin_reject}, {acc[i], ~acc[i]}); end
            total++; if (ifa.credit !== cred[i]) begin bad++; $display("FAIL coins_credit[%0d] got=%0d want=%0d", i, ifa.credit, cred[i]); end
        end
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
        cycle();
        total++; if ({ifa.coin_accept, ifa.coin_reject} !== 2'b00) begin bad++; $display("FAIL coins_pulse_clear got=%b want=00", {ifa.coin_accept, ifa.coin_reject}); end
    endtask

    task automatic test_max_credit();
        pulse_reset();
        add_coins_a(4'd10, 19);
        add_coins_a(4'd5, 1);
        total++; if (ifa.credit !== 8'd195) begin bad++; $display("FAIL max_build got=%0d want=195", ifa.credit); end
        drive_a(1'b1, 4'd10, 1'b0, 8'd0, 1'b0);
        cycle();
        total++; if ({ifa.coin_accept, ifa.coin_reject} !== 2'b01) begin bad++; $display("FAIL max_reject got=%b want=01", {ifa.coin_accept, ifa.coin_reject}); end
        total++; if (ifa.credit !== 8'd195) begin bad++; $display("FAIL max_reject_credit got=%0d want=195", ifa.credit); end
        drive_a(1'b1, 4'd5, 1'b0, 8'd0, 1'b0);
        cycle();
        total++; if ({ifa.coin_accept, ifa.coin_reject} !== 2'b10) begin bad++; $display("FAIL max_accept got=%b want=10", {ifa.coin_accept, ifa.coin_reject}); end
        total++; if (ifa.credit !== 8'd200) begin bad++; $display("FAIL max_accept_credit got=%0d want=200", ifa.credit); end
        // Vend 10 with coin 10 at 200: coin fits only against the post-vend credit.
        drive_a(1'b1, 4'd10, 1'b1, 8'd10, 1'b0);
        cycle();
        total++; if ({ifa.vend_ack, ifa.coin_accept} !== 2'b11) begin bad++; $display("FAIL max_vend_coin got=%b want=11", {ifa.vend_ack, ifa.coin_accept}); end
        total++; if (ifa.credit !== 8'd200) begin bad++; $display("FAIL max_vend_coin_credit got=%0d want=200", ifa.credit); end
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_vend();
        pulse_reset();
        add_coins_a(4'd10, 1);
        add_coins_a(4'd1, 2);
        drive_a(1'b1, 4'd5, 1'b1, 8'd15, 1'b0);
        cycle();
        total++; if ({ifa.vend_ack, ifa.vend_nak, ifa.coin_accept} !== 3'b011) begin bad++; $display("FAIL vend_nak_coin got=%b want=011", {ifa.vend_ack, ifa.vend_nak, ifa.coin_accept}); end
        total++; if (ifa.credit !== 8'd17) begin bad++; $display("FAIL vend_nak_credit got=%0d want=17", ifa.credit); end
        drive_a(1'b0, 4'd0, 1'b1, 8'd15, 1'b0);
        cycle();
        total++; if ({ifa.vend_ack, ifa.vend_nak} !== 2'b10) begin bad++; $display("FAIL vend_ack got=%b want=10", {ifa.vend_ack, ifa.vend_nak}); end
        total++; if (ifa.credit !== 8'd2) begin bad++; $display("FAIL vend_ack_credit got=%0d want=2", ifa.credit); end
        drive_a(1'b0, 4'd0, 1'b1, 8'd2, 1'b0);
        cycle();
        total++; if ({ifa.vend_ack, ifa.credit} !== {1'b1, 8'd0}) begin bad++; $display("FAIL vend_exact got=%0d want=%0d", {ifa.vend_ack, ifa.credit}, {1'b1, 8'd0}); end
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_refund();
        int exp_coin [5] = '{10, 10, 5, 1, 1};
        pulse_reset();
        add_coins_a(4'd10, 2);
        add_coins_a(4'd5, 1);
        add_coins_a(4'd1, 2);
        ifa.refund_ready = 1'b1;
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b1);
        cycle();
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            total++; if ({ifa.busy, ifa.refund_valid, ifa.refund_coin} !== {1'b1, 1'b1, exp_coin[i][3:0]}) begin bad++; $display("FAIL refund_coin[%0d] got=%0d want=%0d", i, ifa.refund_coin, exp_coin[i]); end
            cycle();
        end
        total++; if ({ifa.refund_done, ifa.refund_valid, ifa.busy} !== 3'b100) begin bad++; $display("FAIL refund_done got=%b want=100", {ifa.refund_done, ifa.refund_valid, ifa.busy}); end
        total++; if (ifa.credit !== 8'd0) begin bad++; $display("FAIL refund_credit got=%0d want=0", ifa.credit); end
        cycle();
        total++; if (ifa.refund_done !== 1'b0) begin bad++; $display("FAIL refund_done_once got=%b want=0", ifa.refund_done); end
        // Refund request with zero credit finishes immediately.
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b1);
        cycle();
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
        total++; if ({ifa.refund_done, ifa.busy, ifa.refund_valid} !== 3'b100) begin bad++; $display("FAIL refund_zero got=%b want=100", {ifa.refund_done, ifa.busy, ifa.refund_valid}); end
    endtask

    task automatic test_refund_stall();
        ifa.refund_ready = 1'b0;
        add_coins_a(4'd10, 1);
        add_coins_a(4'd5, 1);
        add_coins_a(4'd1, 1);
        drive_a(1'b1, 4'd5, 1'b1, 8'd1, 1'b1);
        cycle();
        total++; if ({ifa.coin_reject, ifa.vend_nak, ifa.busy} !== 3'b111) begin bad++; $display("FAIL stall_entry got=%b want=111", {ifa.coin_reject, ifa.vend_nak, ifa.busy}); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++; if ({ifa.refund_valid, ifa.refund_coin, ifa.credit} !== {1'b1, 4'd10, 8'd16}) begin bad++; $display("FAIL stall_hold[%0d] got=%0d/%0d want=10/16", i, ifa.refund_coin, ifa.credit); end
            if (i == 0) begin
                total++; if ({ifa.coin_reject, ifa.vend_nak} !== 2'b11) begin bad++; $display("FAIL stall_busy_reqs got=%b want=11", {ifa.coin_reject, ifa.vend_nak}); end
                drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
            end
        end
        ifa.refund_ready = 1'b1;
        for (int i = 0; (i < 10) && (ifa.refund_done !== 1'b1); i++) begin
            cycle();
        end
        total++; if ({ifa.refund_done, ifa.credit} !== {1'b1, 8'd0}) begin bad++; $display("FAIL stall_drain got=%0d want=%0d", {ifa.refund_done, ifa.credit}, {1'b1, 8'd0}); end
    endtask

    task automatic test_reset_mid_refund();
        pulse_reset();
        ifa.refund_ready = 1'b0;
        add_coins_a(4'd10, 1);
        add_coins_a(4'd5, 1);
        add_coins_a(4'd1, 1);
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b1);
        cycle();
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
        total++; if ({ifa.busy, ifa.credit} !== {1'b1, 8'd16}) begin bad++; $display("FAIL midrst_setup got=%0d want=%0d", {ifa.busy, ifa.credit}, {1'b1, 8'd16}); end
        rst = 1'b1;
        #1;
        total++; if ({ifa.busy, ifa.refund_valid, ifa.refund_coin, ifa.credit} !== 14'd0) begin bad++; $display("FAIL midrst_async got=%0d want=0", {ifa.busy, ifa.refund_valid, ifa.refund_coin, ifa.credit}); end
        rst = 1'b0;
        drive_a(1'b1, 4'd5, 1'b0, 8'd0, 1'b0);
        cycle();
        drive_a(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
        total++; if ({ifa.coin_accept, ifa.credit} !== {1'b1, 8'd5}) begin bad++; $display("FAIL midrst_coin got=%0d want=%0d", {ifa.coin_accept, ifa.credit}, {1'b1, 8'd5}); end
    endtask

    task automatic test_mask();
        int exp_coin [3] = '{5, 2, 1};
        ifb.refund_ready = 1'b1;
        drive_b(1'b1, 4'd2, 1'b0);
        cycle();
        total++; if ({ifb.coin_accept, ifb.credit} !== {1'b1, 8'd2}) begin bad++; $display("FAIL mask_coin2 got=%0d want=%0d", {ifb.coin_accept, ifb.credit}, {1'b1, 8'd2}); end
        drive_b(1'b1, 4'd10, 1'b0);
        cycle();
        total++; if ({ifb.coin_reject, ifb.credit} !== {1'b1, 8'd2}) begin bad++; $display("FAIL mask_coin10 got=%0d want=%0d", {ifb.coin_reject, ifb.credit}, {1'b1, 8'd2}); end
        drive_b(1'b1, 4'd5, 1'b0);
        cycle();
        drive_b(1'b1, 4'd1, 1'b0);
        cycle();
        drive_b(1'b0, 4'd0, 1'b1);
        cycle();
        drive_b(1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++; if ({ifb.refund_valid, ifb.refund_coin} !== {1'b1, exp_coin[i][3:0]}) begin bad++; $display("FAIL mask_refund[%0d] got=%0d want=%0d", i, ifb.refund_coin, exp_coin[i]); end
            cycle();
        end
        total++; if ({ifb.refund_done, ifb.credit} !== {1'b1, 8'd0}) begin bad++; $display("FAIL mask_done got=%0d want=%0d", {ifb.refund_done, ifb.credit}, {1'b1, 8'd0}); end
    endtask

    initial begin
        test_reset();
        test_coins();
        test_max_credit();
        test_vend();
        test_refund();
        test_refund_stall();
        test_reset_mid_refund();
        test_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter CREDIT_W, default 8, width of the credit register and price bus.
REQ-002 Parameter MAX_CREDIT, default 200, highest credit the block shall hold.
REQ-003 Parameter ACCEPT_MASK, default 16'h0422, legal coin values (bit n set = value n legal; default 1, 5, 10 NIS).
REQ-004 Ports:
- clk  in  1  single clock; one clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- coin_valid  in  1  coin presented this cycle.
- coin_input  in  4  coin value.
- vend_req  in  1  purchase request.
- vend_price  in  CREDIT_W  price, sampled with vend_req.
- refund_req  in  1  return all credit.
- refund_ready  in  1  hopper accepts refund_coin.
- credit  out  CREDIT_W  current credit.
- coin_accept  out  1  one-cycle pulse.
- coin_reject  out  1  one-cycle pulse, coin physically returned.
- vend_ack  out  1  one-cycle pulse.
- vend_nak  out  1  one-cycle pulse.
- refund_valid  out  1  refund coin offered.
- refund_coin  out  4  value of offered refund coin.
- refund_done  out  1  one-cycle pulse at refund end.
- busy  out  1  high in REFUND state.

Function
REQ-005 All outputs shall be registered; pulses appear the cycle after the sampling edge.
REQ-006 FSM states shall be IDLE and REFUND.
REQ-007 In IDLE, priority shall be refund_req > vend_req > coin_valid for sequencing within one cycle.
REQ-008 A coin shall be legal iff ACCEPT_MASK[coin_input] is 1 and coin_input is nonzero.
REQ-009 An illegal coin shall give coin_reject, credit unchanged.
REQ-010 Vend shall be evaluated against credit at the start of the cycle: credit >= vend_price gives vend_ack and credit minus price; otherwise vend_nak, credit unchanged.
REQ-011 A legal coin in the same cycle shall be evaluated against the post-vend credit; sum <= MAX_CREDIT gives coin_accept and adds, else coin_reject.
REQ-012 Credit arithmetic shall be computed CREDIT_W+1 bits wide; credit shall never wrap or exceed MAX_CREDIT.
REQ-013 refund_req in IDLE shall enter REFUND next cycle; same-cycle coin gets coin_reject, same-cycle vend_req gets vend_nak.
REQ-014 refund_req with credit 0 shall pulse refund_done directly and stay in IDLE.
REQ-015 In REFUND, refund_valid shall be high with refund_coin = largest legal value <= credit; value and valid held stable until refund_ready.
REQ-016 On refund_valid && refund_ready, credit shall decrement by refund_coin; next coin offered the following cycle (zero or one idle cycle allowed, must be fixed and documented).
REQ-017 When credit reaches 0, refund_valid shall drop, refund_done pulse once, FSM return to IDLE.
REQ-018 In REFUND every coin_valid shall give coin_reject, every vend_req vend_nak; refund_req ignored.
REQ-019 Elaboration shall fail if ACCEPT_MASK[1] is 0 or MAX_CREDIT >= 2**CREDIT_W.

Reset
REQ-020 rst high shall immediately force IDLE, credit 0, all pulse outputs 0, refund_valid 0, refund_coin 0, busy 0, including mid-refund (remaining credit is discarded).

Structure
REQ-021 Shared package vend_pkg shall hold the state enum, COIN_W = 4, and default ACCEPT_MASK.
REQ-022 Legality check and largest-denomination lookup shall sit in combinational sub-module coin_check, parametrised by ACCEPT_MASK.

Verification
REQ-023 Coins 1, 5, 10, 3 in consecutive cycles -> accept, accept, accept, reject; credit 16.
REQ-024 Credit 195, coin 10 -> coin_reject, credit 195; coin 5 -> accept, credit 200.
REQ-025 Credit 12, vend 15 plus coin 5 same cycle -> vend_nak, coin_accept, credit 17; vend 15 -> vend_ack, credit 2.
REQ-026 Credit 27, refund_req, refund_ready held high -> coins 10, 10, 5, 1, 1, then refund_done, credit 0; refund_ready stalled 3 cycles -> refund_coin stable throughout.
REQ-027 rst asserted during refund with credit 16 -> outputs zero asynchronously, IDLE, next coin 5 accepted, credit 5.
REQ-028 ACCEPT_MASK = 16'h0026 (1, 2, 5): coin 2 accepted, coin 10 rejected; refund of 8 -> 5, 2, 1.
